// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle add/sub/logic/slt, plus iterative shift-add multiply
// and restoring divide/remainder that retire one bit per clock.
module alu_mc #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [XLEN-1:0] x,
  input  logic [XLEN-1:0] y,
  input  logic [3:0]      aluControl,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            busy,
  output logic            done
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_MUL  = 4'b1000;
  localparam logic [3:0] OP_DIVU = 4'b1001;
  localparam logic [3:0] OP_REMU = 4'b1010;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_r, state_next_s;
  logic [CW-1:0]   cnt_r;
  logic [3:0]      op_r;
  logic [XLEN-1:0] a_r;       // multiplicand, or dividend shifting out / quotient shifting in
  logic [XLEN-1:0] b_r;       // multiplier (shifts right), or divisor
  logic [XLEN-1:0] acc_r;     // product accumulator, or partial remainder
  logic [XLEN-1:0] result_r;
  logic            zero_r;

  logic            accept_s;
  logic [XLEN-1:0] mul_acc_s;
  logic [XLEN:0]   rem_sh_s;
  logic [XLEN:0]   diff_s;
  logic            div_ge_s;
  logic [XLEN-1:0] rem_next_s;
  logic [XLEN-1:0] quo_next_s;
  logic [XLEN-1:0] iter_res_s;
  logic [XLEN-1:0] single_res_s;

  function automatic logic is_iter(input logic [3:0] op);
    logic r;
    case (op)
      OP_MUL, OP_DIVU, OP_REMU: r = 1'b1;
      default:                  r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic [XLEN-1:0] single_op(input logic [3:0] op,
                                                input logic [XLEN-1:0] a,
                                                input logic [XLEN-1:0] b);
    logic [XLEN-1:0] r;
    case (op)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_SLT:  r = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      default: r = {XLEN{1'b0}};
    endcase
    return r;
  endfunction

  assign accept_s     = start && (state_r != S_RUN);
  assign single_res_s = single_op(aluControl, x, y);

  // One iteration step of multiply and restoring divide
  always_comb begin
    mul_acc_s  = b_r[0] ? (acc_r + a_r) : acc_r;
    rem_sh_s   = {acc_r, a_r[XLEN-1]};
    diff_s     = rem_sh_s - {1'b0, b_r};
    div_ge_s   = ~diff_s[XLEN];
    rem_next_s = rem_sh_s[XLEN-1:0];
    if (div_ge_s) begin
      rem_next_s = diff_s[XLEN-1:0];
    end else begin
      rem_next_s = rem_sh_s[XLEN-1:0];
    end
    quo_next_s = {a_r[XLEN-2:0], div_ge_s};
    case (op_r)
      OP_MUL:  iter_res_s = mul_acc_s;
      OP_DIVU: iter_res_s = quo_next_s;
      default: iter_res_s = rem_next_s;
    endcase
  end

  // Next-state decode
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      S_IDLE, S_DONE: begin
        if (accept_s) begin
          if (is_iter(aluControl)) begin
            state_next_s = S_RUN;
          end else begin
            state_next_s = S_DONE;
          end
        end else begin
          state_next_s = S_IDLE;
        end
      end
      S_RUN: begin
        if (cnt_r == CNT_ZERO) begin
          state_next_s = S_DONE;
        end else begin
          state_next_s = S_RUN;
        end
      end
      default: state_next_s = S_IDLE;
    endcase
  end

  // State, operand, iteration and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= S_IDLE;
      cnt_r    <= CNT_ZERO;
      op_r     <= 4'b0000;
      a_r      <= {XLEN{1'b0}};
      b_r      <= {XLEN{1'b0}};
      acc_r    <= {XLEN{1'b0}};
      result_r <= {XLEN{1'b0}};
      zero_r   <= 1'b1;
    end else begin
      state_r <= state_next_s;
      if (accept_s) begin
        op_r  <= aluControl;
        a_r   <= x;
        b_r   <= y;
        acc_r <= {XLEN{1'b0}};
        if (is_iter(aluControl)) begin
          cnt_r <= CNT_LAST;
        end else begin
          result_r <= single_res_s;
          zero_r   <= (single_res_s == {XLEN{1'b0}});
        end
      end else if (state_r == S_RUN) begin
        if (op_r == OP_MUL) begin
          acc_r <= mul_acc_s;
          a_r   <= {a_r[XLEN-2:0], 1'b0};
          b_r   <= {1'b0, b_r[XLEN-1:1]};
        end else begin
          acc_r <= rem_next_s;
          a_r   <= quo_next_s;
        end
        if (cnt_r == CNT_ZERO) begin
          result_r <= iter_res_s;
          zero_r   <= (iter_res_s == {XLEN{1'b0}});
        end else begin
          cnt_r <= cnt_r - CNT_ONE;
        end
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

  assign result = result_r;
  assign zero   = zero_r;
  assign busy   = (state_r == S_RUN);
  assign done   = (state_r == S_DONE);

endmodule
